// File: rtl/zpu_mem_arbiter_if.sv
// Bus bundle between the two ZPU-style masters, the arbiter and the single-port RAM.
interface zpu_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic              a_read;
  logic              a_write;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [DATA_W-1:0] a_rdata;
  logic              a_done;

  logic              b_read;
  logic              b_write;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic [DATA_W-1:0] b_rdata;
  logic              b_done;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic              grant_b;

  modport slave (
    input  a_read, a_write, a_addr, a_wdata,
    output a_rdata, a_done,
    input  b_read, b_write, b_addr, b_wdata,
    output b_rdata, b_done,
    output ram_addr, ram_we, ram_din,
    input  ram_dout,
    output grant_b
  );

  modport master (
    output a_read, a_write, a_addr, a_wdata,
    input  a_rdata, a_done,
    output b_read, b_write, b_addr, b_wdata,
    input  b_rdata, b_done,
    input  ram_addr, ram_we, ram_din,
    output ram_dout,
    input  grant_b
  );
endinterface

// File: rtl/zpu_mem_arbiter.sv
// Two-master arbiter for the 1-cycle synchronous internal RAM; one access every 4 cycles,
// done pulse three cycles after the request is seen in IDLE.
module zpu_mem_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter bit          B_PRIORITY = 1'b0
) (
  input logic              clk,
  input logic              reset,
  zpu_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              ram_we_q, ram_we_d;
  logic              is_wr_q, is_wr_d;
  logic              grant_b_q, grant_b_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              a_done_q, a_done_d;
  logic              b_done_q, b_done_d;
  logic              a_req, b_req, win_b;

  always_comb begin
    a_req = bus.a_read | bus.a_write;
    b_req = bus.b_read | bus.b_write;
    // on a tie the previous owner loses unless B has fixed priority
    if (a_req && b_req) win_b = B_PRIORITY ? 1'b1 : ~grant_b_q;
    else                win_b = b_req;
  end

  always_comb begin
    state_d    = state_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = 1'b0;
    is_wr_d    = is_wr_q;
    grant_b_d  = grant_b_q;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    a_done_d   = 1'b0;
    b_done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          grant_b_d  = win_b;
          ram_addr_d = win_b ? bus.b_addr  : bus.a_addr;
          ram_din_d  = win_b ? bus.b_wdata : bus.a_wdata;
          // read+write together counts as a write
          is_wr_d    = win_b ? bus.b_write : bus.a_write;
          ram_we_d   = is_wr_d;
          state_d    = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (!is_wr_q) begin
          if (grant_b_q) b_rdata_d = bus.ram_dout;
          else           a_rdata_d = bus.ram_dout;
        end
        if (grant_b_q) b_done_d = 1'b1;
        else           a_done_d = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_we_q   <= 1'b0;
      is_wr_q    <= 1'b0;
      grant_b_q  <= 1'b1;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_done_q   <= 1'b0;
      b_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
      is_wr_q    <= is_wr_d;
      grant_b_q  <= grant_b_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      a_done_q   <= a_done_d;
      b_done_q   <= b_done_d;
    end
  end

  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_din  = ram_din_q;
  assign bus.ram_we   = ram_we_q;
  assign bus.grant_b  = grant_b_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;
  assign bus.a_done   = a_done_q;
  assign bus.b_done   = b_done_q;

endmodule

// File: tb/tb_zpu_mem_arbiter.sv
// Bench for zpu_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level scheduling model (one 4-cycle access at a time, shadow memory).
module tb_zpu_mem_arbiter;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned NRAND = 600;

  logic clk, reset, mem_clear;
  int   checks, errors;
  logic [DW-1:0] mem0 [0:(1<<AW)-1];
  logic [DW-1:0] mem1 [0:(1<<AW)-1];

  zpu_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) u_if0 ();
  zpu_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) u_if1 ();

  zpu_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .B_PRIORITY(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(u_if0.slave));
  zpu_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .B_PRIORITY(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(u_if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle synchronous RAMs behind each arbiter
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < (1 << AW); i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
    end else begin
      if (u_if0.ram_we === 1'b1) mem0[u_if0.ram_addr] <= u_if0.ram_din;
      if (u_if1.ram_we === 1'b1) mem1[u_if1.ram_addr] <= u_if1.ram_din;
    end
    u_if0.ram_dout <= mem0[u_if0.ram_addr];
    u_if1.ram_dout <= mem1[u_if1.ram_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of run, expected finish before timeout");
    $fatal(1, "timeout");
  end

  task automatic clear_inputs();
    u_if0.a_read = 0; u_if0.a_write = 0; u_if0.a_addr = '0; u_if0.a_wdata = '0;
    u_if0.b_read = 0; u_if0.b_write = 0; u_if0.b_addr = '0; u_if0.b_wdata = '0;
    u_if1.a_read = 0; u_if1.a_write = 0; u_if1.a_addr = '0; u_if1.a_wdata = '0;
    u_if1.b_read = 0; u_if1.b_write = 0; u_if1.b_addr = '0; u_if1.b_wdata = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    @(negedge clk); reset = 1;
    @(negedge clk); @(negedge clk); reset = 0;
  endtask

  // One transaction on instance 0, started at a negedge; returns latency and bus observations.
  task automatic run0(input bit pb, input bit rd, input bit wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, output int lat, output logic [AW-1:0] iss_addr,
                      output int we_cnt, output int oth);
    lat = -1; we_cnt = 0; oth = 0; iss_addr = '0;
    if (pb) begin u_if0.b_read = rd; u_if0.b_write = wr; u_if0.b_addr = addr; u_if0.b_wdata = wd; end
    else    begin u_if0.a_read = rd; u_if0.a_write = wr; u_if0.a_addr = addr; u_if0.a_wdata = wd; end
    for (int i = 0; i <= 12; i++) begin
      if (i == 1) iss_addr = u_if0.ram_addr;
      if (u_if0.ram_we === 1'b1) we_cnt++;
      if ((pb ? u_if0.a_done : u_if0.b_done) === 1'b1) oth++;
      if ((pb ? u_if0.b_done : u_if0.a_done) === 1'b1) begin lat = i; break; end
      @(negedge clk);
    end
    if (pb) begin u_if0.b_read = 0; u_if0.b_write = 0; end
    else    begin u_if0.a_read = 0; u_if0.a_write = 0; end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (u_if0.a_done !== 1'b0) begin errors++; $display("FAIL reset_a_done: got %b expected 0", u_if0.a_done); end
    checks++; if (u_if0.b_done !== 1'b0) begin errors++; $display("FAIL reset_b_done: got %b expected 0", u_if0.b_done); end
    checks++; if (u_if0.ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b expected 0", u_if0.ram_we); end
    checks++; if (u_if0.ram_addr !== '0) begin errors++; $display("FAIL reset_ram_addr: got %h expected 0", u_if0.ram_addr); end
    checks++; if (u_if0.ram_din !== '0) begin errors++; $display("FAIL reset_ram_din: got %h expected 0", u_if0.ram_din); end
    checks++; if (u_if0.a_rdata !== '0) begin errors++; $display("FAIL reset_a_rdata: got %h expected 0", u_if0.a_rdata); end
    checks++; if (u_if0.b_rdata !== '0) begin errors++; $display("FAIL reset_b_rdata: got %h expected 0", u_if0.b_rdata); end
    checks++; if (u_if0.grant_b !== 1'b1) begin errors++; $display("FAIL reset_grant_b: got %b expected 1", u_if0.grant_b); end
    checks++; if (u_if1.grant_b !== 1'b1) begin errors++; $display("FAIL reset_grant_b_prio: got %b expected 1", u_if1.grant_b); end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_read_a();
    int lat, we, oth; logic [AW-1:0] ia;
    run0(0, 0, 1, 10'h005, 32'hDEADBEEF, lat, ia, we, oth);
    checks++; if (lat !== 3) begin errors++; $display("FAIL a_write_latency: got %0d expected 3", lat); end
    checks++; if (we !== 1) begin errors++; $display("FAIL a_write_we_cycles: got %0d expected 1", we); end
    run0(0, 1, 0, 10'h005, 32'h0, lat, ia, we, oth);
    checks++; if (lat !== 3) begin errors++; $display("FAIL a_read_latency: got %0d expected 3", lat); end
    checks++; if (ia !== 10'h005) begin errors++; $display("FAIL a_read_issue_addr: got %h expected 005", ia); end
    checks++; if (we !== 0) begin errors++; $display("FAIL a_read_we_cycles: got %0d expected 0", we); end
    checks++; if (oth !== 0) begin errors++; $display("FAIL a_read_b_done: got %0d expected 0", oth); end
    checks++; if (u_if0.a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL a_read_data: got %h expected deadbeef", u_if0.a_rdata); end
  endtask

  task automatic test_write_read_b();
    int lat, we, oth; logic [AW-1:0] ia;
    run0(1, 0, 1, 10'h3FF, 32'h12345678, lat, ia, we, oth);
    checks++; if (lat !== 3) begin errors++; $display("FAIL b_write_latency: got %0d expected 3", lat); end
    checks++; if (we !== 1) begin errors++; $display("FAIL b_write_we_cycles: got %0d expected 1", we); end
    checks++; if (oth !== 0) begin errors++; $display("FAIL b_write_a_done: got %0d expected 0", oth); end
    checks++; if (mem0[10'h3FF] !== 32'h12345678) begin errors++; $display("FAIL b_write_ram: got %h expected 12345678", mem0[10'h3FF]); end
    checks++; if (u_if0.b_rdata !== '0) begin errors++; $display("FAIL b_write_rdata: got %h expected 0", u_if0.b_rdata); end
    run0(1, 1, 0, 10'h3FF, 32'h0, lat, ia, we, oth);
    checks++; if (lat !== 3) begin errors++; $display("FAIL b_read_latency: got %0d expected 3", lat); end
    checks++; if (ia !== 10'h3FF) begin errors++; $display("FAIL b_read_issue_addr: got %h expected 3ff", ia); end
    checks++; if (u_if0.b_rdata !== 32'h12345678) begin errors++; $display("FAIL b_read_data: got %h expected 12345678", u_if0.b_rdata); end
    checks++; if (u_if0.a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b_read_a_rdata: got %h expected deadbeef", u_if0.a_rdata); end
    checks++; if (oth !== 0) begin errors++; $display("FAIL b_read_a_done: got %0d expected 0", oth); end
  endtask

  task automatic test_read_write_both();
    int lat, we, oth, extra; logic [AW-1:0] ia;
    run0(0, 1, 1, 10'h010, 32'hCAFEF00D, lat, ia, we, oth);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      if (u_if0.a_done === 1'b1) extra++;
      @(negedge clk);
    end
    checks++; if (lat !== 3) begin errors++; $display("FAIL rw_latency: got %0d expected 3", lat); end
    checks++; if (we !== 1) begin errors++; $display("FAIL rw_we_cycles: got %0d expected 1", we); end
    checks++; if (mem0[10'h010] !== 32'hCAFEF00D) begin errors++; $display("FAIL rw_ram: got %h expected cafef00d", mem0[10'h010]); end
    checks++; if (u_if0.a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rw_rdata_kept: got %h expected deadbeef", u_if0.a_rdata); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL rw_extra_done: got %0d expected 0", extra); end
  endtask

  task automatic test_tie_round_robin();
    int at[$], bt[$];
    int exp_a[3] = '{3, 11, 19};
    int exp_b[3] = '{7, 15, 23};
    apply_reset();
    u_if0.a_addr = 10'h005; u_if0.b_addr = 10'h3FF;
    u_if0.a_read = 1; u_if0.b_read = 1;
    for (int i = 0; i <= 40 && (at.size() < 3 || bt.size() < 3); i++) begin
      if (u_if0.a_done === 1'b1) begin at.push_back(i); u_if0.a_read = 0; end
      else if (!u_if0.a_read && at.size() < 3) u_if0.a_read = 1;
      if (u_if0.b_done === 1'b1) begin bt.push_back(i); u_if0.b_read = 0; end
      else if (!u_if0.b_read && bt.size() < 3) u_if0.b_read = 1;
      @(negedge clk);
    end
    u_if0.a_read = 0; u_if0.b_read = 0;
    checks++; if (at.size() !== 3) begin errors++; $display("FAIL rr_a_count: got %0d expected 3", at.size()); end
    checks++; if (bt.size() !== 3) begin errors++; $display("FAIL rr_b_count: got %0d expected 3", bt.size()); end
    for (int j = 0; j < 3; j++) begin
      if (j < at.size()) begin
        checks++; if (at[j] !== exp_a[j]) begin errors++; $display("FAIL rr_a_done_%0d: got cycle %0d expected %0d", j, at[j], exp_a[j]); end
      end
      if (j < bt.size()) begin
        checks++; if (bt[j] !== exp_b[j]) begin errors++; $display("FAIL rr_b_done_%0d: got cycle %0d expected %0d", j, bt[j], exp_b[j]); end
      end
    end
    checks++; if (u_if0.a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rr_a_rdata: got %h expected deadbeef", u_if0.a_rdata); end
    checks++; if (u_if0.b_rdata !== 32'h12345678) begin errors++; $display("FAIL rr_b_rdata: got %h expected 12345678", u_if0.b_rdata); end
    @(negedge clk);
  endtask

  task automatic test_b_priority();
    int ta, tb, tb2, bcnt;
    apply_reset();
    u_if1.a_addr = 10'h001; u_if1.b_addr = 10'h002;
    for (int p = 0; p < 3; p++) begin
      ta = -1; tb = -1;
      u_if1.a_read = 1; u_if1.b_read = 1;
      for (int i = 0; i <= 12 && (ta < 0 || tb < 0); i++) begin
        if (u_if1.a_done === 1'b1) begin ta = i; u_if1.a_read = 0; end
        if (u_if1.b_done === 1'b1) begin tb = i; u_if1.b_read = 0; end
        @(negedge clk);
      end
      u_if1.a_read = 0; u_if1.b_read = 0;
      checks++; if (tb !== 3) begin errors++; $display("FAIL prio_pair%0d_b: got cycle %0d expected 3", p, tb); end
      checks++; if (ta !== 7) begin errors++; $display("FAIL prio_pair%0d_a: got cycle %0d expected 7", p, ta); end
    end
    // B re-requests right away: it keeps winning, A waits for B to release
    ta = -1; tb2 = -1; bcnt = 0;
    u_if1.a_read = 1; u_if1.b_read = 1;
    for (int i = 0; i <= 16 && ta < 0; i++) begin
      if (u_if1.b_done === 1'b1) begin bcnt++; if (bcnt == 2) tb2 = i; u_if1.b_read = 0; end
      else if (bcnt == 1 && !u_if1.b_read) u_if1.b_read = 1;
      if (u_if1.a_done === 1'b1) begin ta = i; u_if1.a_read = 0; end
      @(negedge clk);
    end
    u_if1.a_read = 0; u_if1.b_read = 0;
    checks++; if (tb2 !== 7) begin errors++; $display("FAIL prio_b_again: got cycle %0d expected 7", tb2); end
    checks++; if (ta !== 11) begin errors++; $display("FAIL prio_a_after_release: got cycle %0d expected 11", ta); end
  endtask

  task automatic test_reset_mid();
    int cnt, lat, we, oth; logic [AW-1:0] ia;
    // read aborted in WAIT
    u_if0.a_addr = 10'h005; u_if0.a_read = 1;
    @(negedge clk); @(negedge clk);
    #1 reset = 1;
    #1;
    checks++; if (u_if0.ram_we !== 1'b0) begin errors++; $display("FAIL rst_wait_ram_we: got %b expected 0", u_if0.ram_we); end
    checks++; if (u_if0.a_rdata !== '0) begin errors++; $display("FAIL rst_wait_a_rdata: got %h expected 0", u_if0.a_rdata); end
    u_if0.a_read = 0;
    @(negedge clk); reset = 0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (u_if0.a_done === 1'b1) cnt++;
      @(negedge clk);
    end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL rst_wait_a_done: got %0d pulses expected 0", cnt); end
    // write aborted in ISSUE: strobe drops at once, RAM never samples it
    u_if0.a_addr = 10'h022; u_if0.a_wdata = 32'h55555555; u_if0.a_write = 1;
    @(negedge clk);
    checks++; if (u_if0.ram_we !== 1'b1) begin errors++; $display("FAIL rst_issue_we_before: got %b expected 1", u_if0.ram_we); end
    #1 reset = 1;
    #1;
    checks++; if (u_if0.ram_we !== 1'b0) begin errors++; $display("FAIL rst_issue_we_async: got %b expected 0", u_if0.ram_we); end
    u_if0.a_write = 0;
    @(negedge clk); reset = 0; @(negedge clk);
    checks++; if (mem0[10'h022] !== '0) begin errors++; $display("FAIL rst_issue_ram: got %h expected 0", mem0[10'h022]); end
    // write already sampled, reset in WAIT
    u_if0.a_addr = 10'h020; u_if0.a_wdata = 32'hA5A5A5A5; u_if0.a_write = 1;
    @(negedge clk); @(negedge clk);
    #1 reset = 1;
    u_if0.a_write = 0;
    @(negedge clk); reset = 0; @(negedge clk);
    checks++; if (mem0[10'h020] !== 32'hA5A5A5A5) begin errors++; $display("FAIL rst_wait_write_kept: got %h expected a5a5a5a5", mem0[10'h020]); end
    // write seen only in IDLE is not performed
    u_if0.a_addr = 10'h021; u_if0.a_wdata = 32'h77777777; u_if0.a_write = 1;
    #2 reset = 1;
    u_if0.a_write = 0;
    @(negedge clk); @(negedge clk); reset = 0; @(negedge clk); @(negedge clk);
    checks++; if (mem0[10'h021] !== '0) begin errors++; $display("FAIL rst_idle_write: got %h expected 0", mem0[10'h021]); end
    run0(0, 1, 0, 10'h005, 32'h0, lat, ia, we, oth);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rst_fresh_latency: got %0d expected 3", lat); end
    checks++; if (u_if0.a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_fresh_data: got %h expected deadbeef", u_if0.a_rdata); end
  endtask

  task automatic test_random();
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    logic [DW-1:0] exp_rd [2];
    logic [DW-1:0] own_val, pd [2];
    logic [AW-1:0] own_addr, pa [2];
    int   pst [2];
    bit   prd [2], pwr [2], dn [2];
    int   free_at, issue_c, done_c, kind;
    bit   own_b, own_wr, last_b, exp_we;
    apply_reset();
    for (int i = 0; i < (1 << AW); i++) shadow[i] = mem0[i];
    free_at = 0; issue_c = -10; done_c = -10; last_b = 1; own_b = 0; own_wr = 0;
    own_addr = '0; own_val = '0;
    for (int p = 0; p < 2; p++) begin
      exp_rd[p] = '0; pst[p] = 0; prd[p] = 0; pwr[p] = 0; pa[p] = '0; pd[p] = '0;
    end
    for (int k = 0; k < int'(NRAND) + 24; k++) begin
      dn[0] = (done_c == k) && !own_b;
      dn[1] = (done_c == k) && own_b;
      if (done_c == k && !own_wr) exp_rd[own_b] = own_val;
      exp_we = (issue_c == k) && own_wr;
      checks++; if (u_if0.a_done !== dn[0]) begin errors++; $display("FAIL rnd_a_done cyc %0d: got %b expected %b", k, u_if0.a_done, dn[0]); end
      checks++; if (u_if0.b_done !== dn[1]) begin errors++; $display("FAIL rnd_b_done cyc %0d: got %b expected %b", k, u_if0.b_done, dn[1]); end
      checks++; if (u_if0.ram_we !== exp_we) begin errors++; $display("FAIL rnd_ram_we cyc %0d: got %b expected %b", k, u_if0.ram_we, exp_we); end
      checks++; if (u_if0.a_rdata !== exp_rd[0]) begin errors++; $display("FAIL rnd_a_rdata cyc %0d: got %h expected %h", k, u_if0.a_rdata, exp_rd[0]); end
      checks++; if (u_if0.b_rdata !== exp_rd[1]) begin errors++; $display("FAIL rnd_b_rdata cyc %0d: got %h expected %h", k, u_if0.b_rdata, exp_rd[1]); end
      if (issue_c == k) begin
        checks++; if (u_if0.ram_addr !== own_addr) begin errors++; $display("FAIL rnd_ram_addr cyc %0d: got %h expected %h", k, u_if0.ram_addr, own_addr); end
      end
      if (done_c == k) begin
        checks++; if (u_if0.grant_b !== own_b) begin errors++; $display("FAIL rnd_grant_b cyc %0d: got %b expected %b", k, u_if0.grant_b, own_b); end
      end
      for (int p = 0; p < 2; p++) begin
        if (dn[p]) pst[p] = 0;
        else if (pst[p] == 1 && issue_c == k && int'(own_b) == p && $urandom_range(3) == 0) pst[p] = 2;
        else if (pst[p] == 0 && k < int'(NRAND) && $urandom_range(2) == 0) begin
          kind = int'($urandom_range(3));
          prd[p] = (kind != 1);
          pwr[p] = (kind == 1 || kind == 2);
          pa[p]  = 10'h3F8 + 10'($urandom_range(15));
          pd[p]  = $urandom;
          pst[p] = 1;
        end
      end
      u_if0.a_read = (pst[0] == 1) && prd[0]; u_if0.a_write = (pst[0] == 1) && pwr[0];
      u_if0.a_addr = pa[0]; u_if0.a_wdata = pd[0];
      u_if0.b_read = (pst[1] == 1) && prd[1]; u_if0.b_write = (pst[1] == 1) && pwr[1];
      u_if0.b_addr = pa[1]; u_if0.b_wdata = pd[1];
      if (k >= free_at && (pst[0] == 1 || pst[1] == 1)) begin
        if (pst[0] == 1 && pst[1] == 1) own_b = !last_b;
        else                            own_b = (pst[1] == 1);
        last_b   = own_b;
        own_wr   = pwr[own_b];
        own_addr = pa[own_b];
        if (own_wr) shadow[own_addr] = pd[own_b];
        else        own_val = shadow[own_addr];
        issue_c = k + 1; done_c = k + 3; free_at = k + 4;
      end
      @(negedge clk);
    end
    checks++; if (pst[0] !== 0 || pst[1] !== 0) begin errors++; $display("FAIL rnd_drain: got pending %0d/%0d expected 0/0", pst[0], pst[1]); end
    clear_inputs();
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1; mem_clear = 1;
    clear_inputs();
    @(negedge clk); @(negedge clk);
    mem_clear = 0;
    test_reset();
    test_read_a();
    test_write_read_b();
    test_read_write_both();
    test_tie_round_robin();
    test_b_priority();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
